vocoder_mixer: RTL and testbench
================================

# vocoder_mixer

Per-band modulation and summing stage for the vocoder datapath. Consumes one frame of `N_FILTERS` band-limited carrier samples and `N_FILTERS` modulator envelopes from the filterbank. Multiplies each carrier by its rectified envelope and sums all enabled bands through a single time-multiplexed multiplier. Emits one saturated 32-bit output sample per accepted frame.

## Interface
- `N_FILTERS`, 9, number of bands per frame.
- `FRAC_BITS`, 16, fractional bits of the envelope; each product is arithmetically shifted right by this amount.
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `valid_in` input 1: single-cycle strobe; carrier, envelope and band-enable inputs are valid in this cycle.
- `carrier_in` input signed 32 x `N_FILTERS`: filtered carrier, one word per band.
- `envelope_in` input signed 32 x `N_FILTERS`: modulator envelope, one word per band.
- `band_en_in` input `N_FILTERS`: per-band enable mask, captured together with the frame.
- `sample_out` output signed 32: mixed output sample.
- `valid_out` output 1: one-cycle strobe that qualifies `sample_out`.
- `busy_out` output 1: high while a frame is in progress.
- `overrun_out` output 1: sticky flag; set when a `valid_in` is dropped.

## Operation
**States**
- IDLE, MAC, DRAIN, OUT.

**Capture (IDLE)**
- On `valid_in`, register all carrier words, envelope words and `band_en_in`.
- Clear the accumulator and set band index k=0.
- Go to MAC.

**Rectify**
- A negative captured envelope word is replaced by 0 when captured.
- Carriers are used signed, as received.

**MAC**
- Each cycle: `prod <= band_en[k] ? carrier[k]*envelope[k] : 0`. This is a full 64-bit signed product.
- In the same cycle, from the second MAC cycle onward: `acc <= acc + (prod >>> FRAC_BITS)`.
- `acc` is 64-bit signed.
- k increments each cycle. After k=N_FILTERS-1, go to DRAIN.

**DRAIN**
- Add the final `prod` into `acc`.
- Go to OUT.

**OUT**
- `sample_out <= sat32(acc)`, where sat32 clamps to [-2^31, 2^31-1].
- `valid_out <= 1` for exactly one cycle.
- Go to IDLE.

**Other rules**
- `sample_out` holds its value until the next OUT.
- `busy_out` is high in MAC, DRAIN and OUT.
- `valid_in` outside IDLE: the frame is dropped, internal state is unaffected, and `overrun_out` is set. `overrun_out` clears only on reset.
- `valid_in` in the OUT cycle is also dropped.
- Input values are ignored when `valid_in` is low.

## Timing
**Reset values**
- While `rst_n_in` is low: state IDLE, `sample_out`=0, `valid_out`=0, `busy_out`=0, `overrun_out`=0, `acc`=0, `prod`=0, k=0.

**Reset deassertion**
- Deassertion is synchronous to `clk_in` via the existing reset synchronizer.
- `valid_in` is accepted on the first edge after deassertion.

**Reset mid-frame**
- The frame is abandoned with no `valid_out`.
- After reset, the block is ready for a new frame.

**Latency**
- Edge E0 samples `valid_in`.
- MAC runs on edges E1..E(N_FILTERS).
- DRAIN is edge E(N_FILTERS+1).
- `sample_out` and `valid_out` update on E(N_FILTERS+2); `valid_out` is high for the cycle after that edge.
- Latency is N_FILTERS+2 cycles: 11 for the default.

**Throughput**
- One frame per N_FILTERS+3 cycles.
- The earliest next accepted `valid_in` is the cycle after OUT, i.e. while `valid_out` is high.

**Other timing rules**
- `busy_out` goes high the cycle after E0 and low the cycle after OUT.
- The multiplier is one registered stage (a single DSP cascade). The critical path is the multiply or the 64-bit add, never both in series.

## Test plan
1. **Unity sum.** N_FILTERS=9, FRAC_BITS=16, all carriers 0x0001_0000, all envelopes 0x0000_8000, mask 0x1FF. Require `sample_out`=0x0004_8000, with `valid_out` exactly 11 cycles after the `valid_in` edge, high for one cycle.
2. **Mask and rectify.**
   - Mask 0x001, carrier[0]=0x0002_0000, envelope[0]=0x0001_0000. Require 0x0002_0000.
   - Repeat with envelope[0]=0xFFFF_0000 (negative). Require 0.
   - Masked-off bands hold 0x7FFF_FFFF and must not contribute.
3. **Saturation.** All carriers 0x7FFF_FFFF, envelopes 0x0001_0000, mask 0x1FF: require 0x7FFF_FFFF. All carriers 0x8000_0000: require 0x8000_0000.
4. **Overrun.**
   - Second `valid_in` 3 cycles after the first: require the first result correct, only one `valid_out`, and `overrun_out` set and held.
   - A `valid_in` in the cycle `valid_out` is high: require it accepted, with no overrun.
5. **Back-to-back.** Frames at spacing 12 with different data. Require each `sample_out` to match the golden model and no overrun.
6. **Reset mid-frame.** Pulse `rst_n_in` low asynchronously 5 cycles after `valid_in`. Require all outputs 0 immediately and no `valid_out`; the next frame must produce the correct result.

Source files
------------

// File: rtl/vocoder_mixer_if.sv
// -----------------------------------------------------------------------------
// vocoder_mixer_if
// Frame bus between the filterbank and the vocoder mixer.
//   valid_in     : single-cycle frame strobe (master -> slave)
//   carrier_in   : N_FILTERS signed 32-bit carrier words, band i in [i]
//   envelope_in  : N_FILTERS signed 32-bit modulator envelopes, band i in [i]
//   band_en_in   : per-band enable mask, sampled with the frame
//   sample_out   : saturated mixed sample (slave -> master)
//   valid_out    : one-cycle strobe qualifying sample_out
//   busy_out     : a frame is being processed
//   overrun_out  : sticky, a frame strobe arrived while busy and was dropped
// -----------------------------------------------------------------------------
interface vocoder_mixer_if #(
    parameter int N_FILTERS = 9
);
    logic                         valid_in;
    logic [N_FILTERS-1:0][31:0]   carrier_in;
    logic [N_FILTERS-1:0][31:0]   envelope_in;
    logic [N_FILTERS-1:0]         band_en_in;
    logic signed [31:0]           sample_out;
    logic                         valid_out;
    logic                         busy_out;
    logic                         overrun_out;

    modport master (
        output valid_in, carrier_in, envelope_in, band_en_in,
        input  sample_out, valid_out, busy_out, overrun_out
    );

    modport slave (
        input  valid_in, carrier_in, envelope_in, band_en_in,
        output sample_out, valid_out, busy_out, overrun_out
    );
endinterface

// File: rtl/vocoder_mixer.sv
// -----------------------------------------------------------------------------
// vocoder_mixer
// Per-band modulation and summing stage. A frame of N_FILTERS carriers and
// envelopes is captured, each carrier is multiplied by its rectified envelope
// through one shared registered multiplier, the shifted products of enabled
// bands are summed in a 64-bit accumulator, and one saturated 32-bit sample is
// emitted per accepted frame.
// Ports:
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset (deassertion already synchronised)
//   bus      : frame bus (slave side), see vocoder_mixer_if
// Latency from the accepting edge to the valid_out edge is N_FILTERS+2 cycles;
// a new frame can be accepted every N_FILTERS+3 cycles.
// -----------------------------------------------------------------------------
module vocoder_mixer #(
    parameter int N_FILTERS = 9,
    parameter int FRAC_BITS = 16
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    vocoder_mixer_if.slave  bus
);

    localparam int KW = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_FILTERS - 1);
    localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
    localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [31:0]     carrier_q  [N_FILTERS];
    logic signed [31:0]     carrier_d  [N_FILTERS];
    logic signed [31:0]     envelope_q [N_FILTERS];
    logic signed [31:0]     envelope_d [N_FILTERS];
    logic [N_FILTERS-1:0]   band_en_q, band_en_d;
    logic signed [63:0]     acc_q, acc_d;
    logic signed [63:0]     prod_q, prod_d;
    logic signed [31:0]     sample_q, sample_d;
    logic                   valid_out_q, valid_out_d;
    logic                   overrun_q, overrun_d;

    // Envelopes are rectified on the way in so the MAC loop never sees a
    // negative gain.
    logic signed [31:0]     env_rect [N_FILTERS];

    generate
        for (genvar gi = 0; gi < N_FILTERS; gi++) begin : g_rect
            assign env_rect[gi] = bus.envelope_in[gi][31] ? 32'sd0
                                                          : $signed(bus.envelope_in[gi]);
        end
    endgenerate

    // Shared multiplier: operands are selected by k and the product lands in
    // prod_q, so the adder only ever sees a registered product.
    logic signed [31:0]     car_sel;
    logic signed [31:0]     env_sel;
    logic signed [63:0]     mult;
    logic signed [63:0]     prod_shift;

    assign car_sel    = carrier_q[k_q];
    assign env_sel    = envelope_q[k_q];
    assign mult       = 64'(car_sel) * 64'(env_sel);
    assign prod_shift = prod_q >>> FRAC_BITS;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        if (v > SAT_MAX) begin
            return 32'sh7FFF_FFFF;
        end else if (v < SAT_MIN) begin
            return 32'sh8000_0000;
        end else begin
            return v[31:0];
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        carrier_d   = carrier_q;
        envelope_d  = envelope_q;
        band_en_d   = band_en_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        sample_d    = sample_q;
        valid_out_d = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.valid_in) begin
                    for (int i = 0; i < N_FILTERS; i++) begin
                        carrier_d[i]  = $signed(bus.carrier_in[i]);
                        envelope_d[i] = env_rect[i];
                    end
                    band_en_d = bus.band_en_in;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = ST_MAC;
                end
            end
            ST_MAC: begin
                prod_d = band_en_q[k_q] ? mult : 64'sd0;
                // prod_q holds a stale value on the first MAC cycle.
                if (k_q != '0) begin
                    acc_d = acc_q + prod_shift;
                end
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                acc_d   = acc_q + prod_shift;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                sample_d    = sat32(acc_q);
                valid_out_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A strobe while busy (including the OUT cycle) is dropped.
        if (bus.valid_in && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            carrier_q   <= '{default: '0};
            envelope_q  <= '{default: '0};
            band_en_q   <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            sample_q    <= '0;
            valid_out_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carrier_q   <= carrier_d;
            envelope_q  <= envelope_d;
            band_en_q   <= band_en_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            sample_q    <= sample_d;
            valid_out_q <= valid_out_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.sample_out  = sample_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.busy_out    = (state_q != ST_IDLE);
    assign bus.overrun_out = overrun_q;

endmodule

// File: tb/tb_vocoder_mixer.sv
// -----------------------------------------------------------------------------
// tb_vocoder_mixer
// Scoreboard bench: expected samples (value and output cycle) are pushed when
// a frame is driven, the monitor records every valid_out, and the main thread
// pops and compares them.
// -----------------------------------------------------------------------------
module tb_vocoder_mixer;

    localparam int NF = 9;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } item_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests_run;
    int   tests_failed;

    logic [31:0] car [NF];
    logic [31:0] env [NF];

    item_t exp_q[$];
    item_t obs_q[$];

    vocoder_mixer_if #(.N_FILTERS(NF)) vif ();

    vocoder_mixer #(
        .N_FILTERS (NF),
        .FRAC_BITS (16)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: record every output strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (rst_n && vif.valid_out) begin
            item_t it;
            it.val = vif.sample_out;
            it.cyc = cyc;
            obs_q.push_back(it);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent golden model of one frame using the current car/env arrays.
    function automatic logic [31:0] golden(input logic [NF-1:0] en);
        longint acc;
        longint c;
        longint e;
        acc = 0;
        for (int i = 0; i < NF; i++) begin
            if (en[i]) begin
                c = longint'($signed(car[i]));
                e = longint'($signed(env[i]));
                if (e < 0) e = 0;
                acc = acc + ((c * e) >>> 16);
            end
        end
        if (acc > 64'sd2147483647)       return 32'h7FFF_FFFF;
        else if (acc < -64'sd2147483648) return 32'h8000_0000;
        else                             return acc[31:0];
    endfunction

    // Drives a one-cycle frame strobe on the next falling edge; the frame is
    // sampled by the following rising edge (E0), so the strobe is expected
    // back 12 counts later on the monitor's cycle count.
    task automatic drive_frame(input logic [NF-1:0] en, input bit accept);
        item_t it;
        @(negedge clk);
        vif.valid_in   = 1'b1;
        vif.band_en_in = en;
        for (int i = 0; i < NF; i++) begin
            vif.carrier_in[i]  = car[i];
            vif.envelope_in[i] = env[i];
        end
        if (accept) begin
            it.val = golden(en);
            it.cyc = cyc + NF + 3;
            exp_q.push_back(it);
        end
        @(negedge clk);
        vif.valid_in = 1'b0;
    endtask

    // Compare outputs against expectations until the scoreboard is empty,
    // bounded in cycles, then watch a little longer for stray strobes.
    task automatic drain(input string tag);
        item_t e;
        item_t o;
        int    n;
        n = 0;
        while ((exp_q.size() > 0) && (n < 200)) begin
            @(negedge clk);
            #1;
            n++;
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_q.size() == 0) begin
                    check_val({tag, "_extra_valid_out"}, 64'(o.val), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] %s: sample 0x%08h at cycle %0d (expect 0x%08h at %0d)",
                             tag, o.val, o.cyc, e.val, e.cyc);
                    check_val({tag, "_sample"}, 64'(o.val), 64'(e.val));
                    check_val({tag, "_latency"}, 64'(o.cyc), 64'(e.cyc));
                end
            end
        end
        check_val({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        #1;
        check_val({tag, "_stray_strobes"}, 64'(obs_q.size()), 64'd0);
        obs_q.delete();
    endtask

    task automatic fill(input logic [31:0] c, input logic [31:0] e);
        for (int i = 0; i < NF; i++) begin
            car[i] = c;
            env[i] = e;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        vif.valid_in    = 1'b0;
        vif.band_en_in  = '0;
        vif.carrier_in  = '0;
        vif.envelope_in = '0;
        fill(32'h0, 32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_sample_out",  64'(vif.sample_out),  64'd0);
        check_val("rst_valid_out",   64'(vif.valid_out),   64'd0);
        check_val("rst_busy_out",    64'(vif.busy_out),    64'd0);
        check_val("rst_overrun_out", 64'(vif.overrun_out), 64'd0);
        rst_n = 1'b1;

        // 1. Unity sum, plus busy timing
        fill(32'h0001_0000, 32'h0000_8000);
        drive_frame(9'h1FF, 1'b1);
        check_val("unity_expected_const", 64'(exp_q[0].val), 64'h0004_8000);
        check_val("unity_busy_after_e0", 64'(vif.busy_out), 64'd1);
        drain("unity");
        check_val("unity_busy_low", 64'(vif.busy_out), 64'd0);

        // 2. Mask and rectify; masked bands carry large values
        fill(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        car[0] = 32'h0002_0000;
        env[0] = 32'h0001_0000;
        drive_frame(9'h001, 1'b1);
        drain("mask");
        env[0] = 32'hFFFF_0000;
        drive_frame(9'h001, 1'b1);
        drain("rectify");

        // 3. Saturation in both directions
        fill(32'h7FFF_FFFF, 32'h0001_0000);
        drive_frame(9'h1FF, 1'b1);
        drain("sat_pos");
        fill(32'h8000_0000, 32'h0001_0000);
        drive_frame(9'h1FF, 1'b1);
        drain("sat_neg");
        check_val("no_overrun_yet", 64'(vif.overrun_out), 64'd0);

        // 4a. Strobe 3 cycles into a frame is dropped and flagged
        fill(32'h0003_0000, 32'h0000_4000);
        drive_frame(9'h0F0, 1'b1);
        @(negedge clk);
        fill(32'h1234_5678, 32'h0765_4321);
        drive_frame(9'h1FF, 1'b0);
        drain("overrun_first");
        check_val("overrun_set",  64'(vif.overrun_out), 64'd1);
        repeat (20) @(negedge clk);
        check_val("overrun_held", 64'(vif.overrun_out), 64'd1);
        do_reset();
        check_val("overrun_cleared", 64'(vif.overrun_out), 64'd0);

        // 4b/5. Back-to-back frames at spacing 12; each next strobe lands
        // in the cycle valid_out of the previous frame is high.
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < NF; i++) begin
                car[i] = $urandom;
                env[i] = (f == 0) ? 32'h0000_8000 : $urandom;
            end
            drive_frame(9'($urandom_range(0, 511)), 1'b1);
            if (f < 4) repeat (10) @(negedge clk);
        end
        drain("b2b");
        check_val("b2b_no_overrun", 64'(vif.overrun_out), 64'd0);

        // 6. Reset mid-frame
        fill(32'h0001_0000, 32'h0001_0000);
        drive_frame(9'h1FF, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_sample_out", 64'(vif.sample_out), 64'd0);
        check_val("midrst_valid_out",  64'(vif.valid_out),  64'd0);
        check_val("midrst_busy_out",   64'(vif.busy_out),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check_val("midrst_no_strobe", 64'(obs_q.size()), 64'd0);
        obs_q.delete();
        fill(32'hFFFF_0000, 32'h0002_0000);
        car[3] = 32'h0005_0000;
        drive_frame(9'h10F, 1'b1);
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
